// File: rtl/gpio_int_arb.sv
// -----------------------------------------------------------------------------
// gpio_int_arb
// Collects eight asynchronous GPIO interrupt sources into a pending register.
// It arbitrates among the enabled pending sources and presents the winner to a
// CPU with an INTR / INTA_N handshake. A small chip-select bus gives access to
// the control registers.
//
// Register map (i_addr_50m):
//   0 MASK  RW  1 = source enabled for arbitration
//   1 PEND  R   pending flags; writing 1 to a bit clears that bit
//   2 MODE  RW  1 = rising-edge detect, 0 = level-high detect
//   3 LAST  RO  {5'b0, last acknowledged INT_CODE}
//
// Ports:
//   clk_50m       in   single clock, rising edge
//   rst_50m       in   synchronous active-high reset
//   gpio_in       in   raw asynchronous interrupt sources
//   i_csn_50m     in   bus chip select, active-low (an access starts on its falling edge)
//   i_wr_50m      in   write strobe
//   i_rd_50m      in   read strobe
//   i_addr_50m    in   register address
//   i_datin_50m   in   write data
//   o_datout_50m  out  read data, nonzero only while rd_valid is high
//   wr_valid      out  write accepted, 1 cycle after the CSN falling edge
//   rd_valid      out  read data valid, 2 cycles after the CSN falling edge
//   INTR          out  interrupt request to the CPU
//   INT_CODE      out  index of the requested source
//   INTA_N        in   CPU acknowledge, active-low
//
// Build option: define GPIO_INT_ARB_RR_EN for round-robin arbitration. The
// search then starts one past the last acknowledged code. When the macro is
// undefined, bit 0 has the highest priority.
// -----------------------------------------------------------------------------
module gpio_int_arb #(
   parameter int N_SRC = 8
) (
   input  logic                     clk_50m,
   input  logic                     rst_50m,
   input  logic [N_SRC-1:0]         gpio_in,
   input  logic                     i_csn_50m,
   input  logic                     i_wr_50m,
   input  logic                     i_rd_50m,
   input  logic [1:0]               i_addr_50m,
   input  logic [7:0]               i_datin_50m,
   output logic [7:0]               o_datout_50m,
   output logic                     wr_valid,
   output logic                     rd_valid,
   output logic                     INTR,
   output logic [$clog2(N_SRC)-1:0] INT_CODE,
   input  logic                     INTA_N
);

   localparam int CW = $clog2(N_SRC);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK} state_t;

   logic [N_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d, gdly_q, gdly_d;
   logic [N_SRC-1:0] mask_q, mask_d, pend_q, pend_d, mode_q, mode_d;
   logic [CW-1:0]    last_q, last_d, code_q, code_d;
   state_t           state_q, state_d;
   logic             csn_dly_q, csn_dly_d;
   logic             wr_valid_q, wr_valid_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_valid_q, rd_valid_d;
   logic [1:0]       rd_addr_q, rd_addr_d;
   logic [7:0]       datout_q, datout_d;
`ifdef GPIO_INT_ARB_RR_EN
   logic [CW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    idx;
   logic             found;
`endif

   logic             csn_fall, wr_hit, rd_hit;
   logic [N_SRC-1:0] set_v, wr_clr, ack_clr, active;
   logic [CW-1:0]    win;

   // NOTE: every signal driven here gets a default first, so no path leaves it
   // unassigned. Without the default, the tool would infer a latch.
   always_comb begin
      sync1_d   = gpio_in;
      sync2_d   = sync1_q;
      gdly_d    = sync2_q;
      csn_dly_d = i_csn_50m;

      // An access is triggered only by the high-to-low transition of CSN, so
      // holding CSN low does not start a second access.
      csn_fall = csn_dly_q & ~i_csn_50m;
      wr_hit   = csn_fall & i_wr_50m;
      rd_hit   = csn_fall & i_rd_50m;

      mask_d = mask_q;
      mode_d = mode_q;
      wr_clr = '0;
      if (wr_hit) begin
         case (i_addr_50m)
            2'd0:    mask_d = i_datin_50m;
            2'd1:    wr_clr = i_datin_50m;
            2'd2:    mode_d = i_datin_50m;
            default: ;
         endcase
      end
      wr_valid_d = wr_hit;

      // Reads take two stages: capture the address, then drive the data for
      // one cycle only.
      rd_pend_d  = rd_hit;
      rd_addr_d  = rd_hit ? i_addr_50m : rd_addr_q;
      rd_valid_d = rd_pend_q;
      datout_d   = '0;
      if (rd_pend_q) begin
         case (rd_addr_q)
            2'd0:    datout_d = mask_q;
            2'd1:    datout_d = pend_q;
            2'd2:    datout_d = mode_q;
            default: datout_d = {{(8-CW){1'b0}}, last_q};
         endcase
      end

      set_v  = (mode_q & sync2_q & ~gdly_q) | (~mode_q & sync2_q);
      active = pend_q & mask_q;

      win = '0;
`ifdef GPIO_INT_ARB_RR_EN
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         idx = ptr_q + CW'(k);
         if (!found && active[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      ptr_d = ptr_q;
`else
      // The loop scans down so that the lowest set index is assigned last and wins.
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) win = CW'(i);
      end
`endif

      state_d = state_q;
      code_d  = code_q;
      last_d  = last_q;
      ack_clr = '0;
      case (state_q)
         ST_IDLE: begin
            if (|active) begin
               state_d = ST_REQ;
               code_d  = win;
            end
         end
         ST_REQ: begin
            // If software masks or clears the source, the request is withdrawn
            // without recording an acknowledge.
            if (!mask_q[code_q] || !pend_q[code_q]) begin
               state_d = ST_IDLE;
            end else if (!INTA_N) begin
               state_d          = ST_ACK;
               ack_clr[code_q]  = 1'b1;
               last_d           = code_q;
`ifdef GPIO_INT_ARB_RR_EN
               ptr_d            = code_q + CW'(1);
`endif
            end
         end
         ST_ACK: begin
            if (INTA_N) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // When a new event and a clear hit the same bit in the same cycle, the
      // new event wins.
      pend_d = (pend_q & ~(wr_clr | ack_clr)) | set_v;
   end

   // NOTE: the state registers use non-blocking assignments. Every flop then
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk_50m) begin
      if (rst_50m) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         gdly_q     <= '0;
         csn_dly_q  <= 1'b1;
         mask_q     <= '0;
         pend_q     <= '0;
         mode_q     <= '1;
         last_q     <= '0;
         code_q     <= '0;
         state_q    <= ST_IDLE;
         wr_valid_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         datout_q   <= '0;
`ifdef GPIO_INT_ARB_RR_EN
         ptr_q      <= '0;
`endif
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         gdly_q     <= gdly_d;
         csn_dly_q  <= csn_dly_d;
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         mode_q     <= mode_d;
         last_q     <= last_d;
         code_q     <= code_d;
         state_q    <= state_d;
         wr_valid_q <= wr_valid_d;
         rd_pend_q  <= rd_pend_d;
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         datout_q   <= datout_d;
`ifdef GPIO_INT_ARB_RR_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

   assign INTR         = (state_q == ST_REQ);
   assign INT_CODE     = code_q;
   assign o_datout_50m = datout_q;
   assign wr_valid     = wr_valid_q;
   assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_gpio_int_arb.sv
// -----------------------------------------------------------------------------
// tb_gpio_int_arb
// Directed testbench for gpio_int_arb. Each scenario task drives its own stimulus
// and compares the outputs against hand-computed values. Inputs are driven and
// outputs sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_gpio_int_arb;

   logic       clk_50m = 1'b0;
   logic       rst_50m = 1'b1;
   logic [7:0] gpio_in = '0;
   logic       i_csn_50m = 1'b1;
   logic       i_wr_50m = 1'b0;
   logic       i_rd_50m = 1'b0;
   logic [1:0] i_addr_50m = '0;
   logic [7:0] i_datin_50m = '0;
   logic [7:0] o_datout_50m;
   logic       wr_valid;
   logic       rd_valid;
   logic       INTR;
   logic [2:0] INT_CODE;
   logic       INTA_N = 1'b1;

   int tests_run = 0;
   int tests_failed = 0;

   gpio_int_arb #(.N_SRC(8)) dut (
      .clk_50m      (clk_50m),
      .rst_50m      (rst_50m),
      .gpio_in      (gpio_in),
      .i_csn_50m    (i_csn_50m),
      .i_wr_50m     (i_wr_50m),
      .i_rd_50m     (i_rd_50m),
      .i_addr_50m   (i_addr_50m),
      .i_datin_50m  (i_datin_50m),
      .o_datout_50m (o_datout_50m),
      .wr_valid     (wr_valid),
      .rd_valid     (rd_valid),
      .INTR         (INTR),
      .INT_CODE     (INT_CODE),
      .INTA_N       (INTA_N)
   );

   always #10 clk_50m = ~clk_50m;

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
      i_csn_50m = 1'b0; i_wr_50m = 1'b1; i_addr_50m = addr; i_datin_50m = data;
      tick();
      tests_run++;
      if (wr_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL wr_valid_pulse addr=%0d got=%b want=1", addr, wr_valid);
      end
      i_csn_50m = 1'b1; i_wr_50m = 1'b0;
      tick();
      tests_run++;
      if (wr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL wr_valid_end addr=%0d got=%b want=0", addr, wr_valid);
      end
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
      i_csn_50m = 1'b0; i_rd_50m = 1'b1; i_addr_50m = addr;
      tick();
      tests_run++;
      if (rd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rd_valid_early addr=%0d got=%b want=0", addr, rd_valid);
      end
      i_csn_50m = 1'b1; i_rd_50m = 1'b0;
      tick();
      data = o_datout_50m;
      tests_run++;
      if (rd_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL rd_valid_pulse addr=%0d got=%b want=1", addr, rd_valid);
      end
      tick();
      tests_run++;
      if (rd_valid !== 1'b0 || o_datout_50m !== 8'h00) begin
         tests_failed++;
         $display("FAIL rd_end addr=%0d valid=%b data=%h want 0/00", addr, rd_valid, o_datout_50m);
      end
   endtask

   task automatic wait_intr(input string name);
      int n = 0;
      while (INTR !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      tests_run++;
      if (INTR !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_intr_timeout got INTR=%b want=1 within 20 cycles", name, INTR);
      end
   endtask

   task automatic ack_pulse(input string name);
      INTA_N = 1'b0;
      tick();
      tests_run++;
      if (INTR !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_ack_drop got INTR=%b want=0", name, INTR);
      end
      INTA_N = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst_50m = 1'b1;
      repeat (3) tick();
      tests_run++;
      if (INTR !== 1'b0 || INT_CODE !== 3'd0 || o_datout_50m !== 8'h00 ||
          wr_valid !== 1'b0 || rd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs INTR=%b code=%0d dat=%h wv=%b rv=%b want 0/0/00/0/0",
                  INTR, INT_CODE, o_datout_50m, wr_valid, rd_valid);
      end
      rst_50m = 1'b0;
      tick();
      bus_read(2'd0, d);
      tests_run++;
      if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_mask got=%h want=00", d); end
      bus_read(2'd2, d);
      tests_run++;
      if (d !== 8'hFF) begin tests_failed++; $display("FAIL reset_mode got=%h want=FF", d); end
      bus_read(2'd1, d);
      tests_run++;
      if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_pend got=%h want=00", d); end
      bus_read(2'd3, d);
      tests_run++;
      if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_last got=%h want=00", d); end
   endtask

   task automatic test_bus_timing();
      logic [7:0] d;
      // Write with CSN held low for three cycles: only one pulse.
      i_csn_50m = 1'b0; i_wr_50m = 1'b1; i_addr_50m = 2'd0; i_datin_50m = 8'h00;
      tick();
      tests_run++;
      if (wr_valid !== 1'b1) begin tests_failed++; $display("FAIL held_wr_first got=%b want=1", wr_valid); end
      tick();
      tests_run++;
      if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL held_wr_second got=%b want=0", wr_valid); end
      tick();
      tests_run++;
      if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL held_wr_third got=%b want=0", wr_valid); end
      i_csn_50m = 1'b1; i_wr_50m = 1'b0;
      tick();

      // Put a rising edge on bit 6 while it is masked; PEND still records it.
      gpio_in = 8'h40;
      repeat (4) tick();
      gpio_in = 8'h00;
      repeat (3) tick();

      // Read PEND with CSN held low: one rd_valid pulse, 2 cycles after the edge.
      i_csn_50m = 1'b0; i_rd_50m = 1'b1; i_addr_50m = 2'd1;
      tick();
      tests_run++;
      if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL held_rd_c1 got=%b want=0", rd_valid); end
      tick();
      tests_run++;
      if (rd_valid !== 1'b1 || o_datout_50m !== 8'h40) begin
         tests_failed++;
         $display("FAIL held_rd_c2 valid=%b data=%h want 1/40", rd_valid, o_datout_50m);
      end
      tick();
      tests_run++;
      if (rd_valid !== 1'b0 || o_datout_50m !== 8'h00) begin
         tests_failed++;
         $display("FAIL held_rd_c3 valid=%b data=%h want 0/00", rd_valid, o_datout_50m);
      end
      tick();
      tests_run++;
      if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL held_rd_c4 got=%b want=0", rd_valid); end
      i_csn_50m = 1'b1; i_rd_50m = 1'b0;
      tick();

      bus_write(2'd1, 8'h40);
      bus_read(2'd1, d);
      tests_run++;
      if (d !== 8'h00) begin tests_failed++; $display("FAIL pend_w1c got=%h want=00", d); end

      bus_write(2'd2, 8'h5A);
      bus_read(2'd2, d);
      tests_run++;
      if (d !== 8'h5A) begin tests_failed++; $display("FAIL mode_rw got=%h want=5A", d); end
      bus_write(2'd2, 8'hFF);

      bus_write(2'd3, 8'hFF);
      bus_read(2'd3, d);
      tests_run++;
      if (d !== 8'h00) begin tests_failed++; $display("FAIL last_ro got=%h want=00", d); end
   endtask

   task automatic test_fixed_prio();
      logic [7:0] d;
      bus_write(2'd0, 8'h0A);
      gpio_in = 8'h0A;
      wait_intr("prio_first");
      tests_run++;
      if (INT_CODE !== 3'd1) begin tests_failed++; $display("FAIL prio_first_code got=%0d want=1", INT_CODE); end
      repeat (2) tick();
      tests_run++;
      if (INTR !== 1'b1 || INT_CODE !== 3'd1) begin
         tests_failed++;
         $display("FAIL prio_hold INTR=%b code=%0d want 1/1", INTR, INT_CODE);
      end
      ack_pulse("prio_first");
      wait_intr("prio_second");
      tests_run++;
      if (INT_CODE !== 3'd3) begin tests_failed++; $display("FAIL prio_second_code got=%0d want=3", INT_CODE); end
      bus_read(2'd3, d);
      tests_run++;
      if (d !== 8'h01) begin tests_failed++; $display("FAIL prio_last1 got=%h want=01", d); end
      ack_pulse("prio_second");
      repeat (3) tick();
      tests_run++;
      if (INTR !== 1'b0 || INT_CODE !== 3'd3) begin
         tests_failed++;
         $display("FAIL prio_quiet INTR=%b code=%0d want 0/3", INTR, INT_CODE);
      end
      bus_read(2'd3, d);
      tests_run++;
      if (d !== 8'h03) begin tests_failed++; $display("FAIL prio_last3 got=%h want=03", d); end
      bus_read(2'd1, d);
      tests_run++;
      if (d !== 8'h00) begin tests_failed++; $display("FAIL prio_pend got=%h want=00", d); end
      gpio_in = 8'h00;
      repeat (3) tick();
   endtask

   task automatic test_cancel();
      logic [7:0] d;
      bus_write(2'd0, 8'h04);
      gpio_in = 8'h04;
      wait_intr("cancel");
      tests_run++;
      if (INT_CODE !== 3'd2) begin tests_failed++; $display("FAIL cancel_code got=%0d want=2", INT_CODE); end
      i_csn_50m = 1'b0; i_wr_50m = 1'b1; i_addr_50m = 2'd0; i_datin_50m = 8'h00;
      tick();
      i_csn_50m = 1'b1; i_wr_50m = 1'b0;
      tick();
      tests_run++;
      if (INTR !== 1'b0) begin tests_failed++; $display("FAIL cancel_drop got INTR=%b want=0", INTR); end
      repeat (2) tick();
      tests_run++;
      if (INTR !== 1'b0) begin tests_failed++; $display("FAIL cancel_stay got INTR=%b want=0", INTR); end
      bus_read(2'd3, d);
      tests_run++;
      if (d !== 8'h03) begin tests_failed++; $display("FAIL cancel_last got=%h want=03", d); end
      bus_read(2'd1, d);
      tests_run++;
      if (d !== 8'h04) begin tests_failed++; $display("FAIL cancel_pend got=%h want=04", d); end
      bus_write(2'd1, 8'h04);
      gpio_in = 8'h00;
      repeat (3) tick();
   endtask

   task automatic test_level();
      logic [7:0] d;
      bus_write(2'd2, 8'h00);
      bus_write(2'd0, 8'h01);
      gpio_in = 8'h01;
      wait_intr("level_first");
      tests_run++;
      if (INT_CODE !== 3'd0) begin tests_failed++; $display("FAIL level_code got=%0d want=0", INT_CODE); end
      INTA_N = 1'b0;
      tick();
      tests_run++;
      if (INTR !== 1'b0) begin tests_failed++; $display("FAIL level_ack_drop got=%b want=0", INTR); end
      bus_read(2'd1, d);
      tests_run++;
      if (d !== 8'h01) begin tests_failed++; $display("FAIL level_pend_kept got=%h want=01", d); end
      tests_run++;
      if (INTR !== 1'b0) begin tests_failed++; $display("FAIL level_no_intr_in_ack got=%b want=0", INTR); end
      INTA_N = 1'b1;
      wait_intr("level_reraise");
      tests_run++;
      if (INT_CODE !== 3'd0) begin tests_failed++; $display("FAIL level_reraise_code got=%0d want=0", INT_CODE); end
      gpio_in = 8'h00;
      repeat (4) tick();
      bus_write(2'd0, 8'h00);
      bus_write(2'd1, 8'hFF);
      bus_write(2'd2, 8'hFF);
      bus_read(2'd1, d);
      tests_run++;
      if (d !== 8'h00) begin tests_failed++; $display("FAIL level_cleanup_pend got=%h want=00", d); end
   endtask

   task automatic test_arbitration_order();
      logic [2:0] exp [4];
`ifdef GPIO_INT_ARB_RR_EN
      exp = '{3'd0, 3'd5, 3'd0, 3'd5};
`else
      exp = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
      bus_write(2'd0, 8'hFF);
      for (int r = 0; r < 4; r++) begin
         gpio_in = 8'h21;
         repeat (4) tick();
         INTA_N = 1'b1;
         wait_intr("order");
         tests_run++;
         if (INT_CODE !== exp[r]) begin
            tests_failed++;
            $display("FAIL order_round%0d got=%0d want=%0d", r, INT_CODE, exp[r]);
         end
         // Hold INTA_N low so that the next edges collect while the FSM stays in ACK.
         gpio_in = 8'h00;
         INTA_N  = 1'b0;
         tick();
         repeat (3) tick();
      end
      INTA_N = 1'b1;
      tick();
      bus_write(2'd0, 8'h00);
      bus_write(2'd1, 8'hFF);
      repeat (2) tick();
      tests_run++;
      if (INTR !== 1'b0) begin tests_failed++; $display("FAIL order_cleanup got INTR=%b want=0", INTR); end
   endtask

   task automatic test_reset_abort();
      logic [7:0] d;
      bus_write(2'd0, 8'h02);
      gpio_in = 8'h02;
      wait_intr("abort");
      tests_run++;
      if (INT_CODE !== 3'd1) begin tests_failed++; $display("FAIL abort_code got=%0d want=1", INT_CODE); end
      i_csn_50m = 1'b0; i_rd_50m = 1'b1; i_addr_50m = 2'd0;
      tick();
      i_csn_50m = 1'b1; i_rd_50m = 1'b0;
      rst_50m = 1'b1;
      tick();
      tests_run++;
      if (INTR !== 1'b0 || INT_CODE !== 3'd0 || rd_valid !== 1'b0 || o_datout_50m !== 8'h00) begin
         tests_failed++;
         $display("FAIL abort_rst INTR=%b code=%0d rv=%b dat=%h want 0/0/0/00",
                  INTR, INT_CODE, rd_valid, o_datout_50m);
      end
      i_csn_50m = 1'b0; i_wr_50m = 1'b1; i_addr_50m = 2'd0; i_datin_50m = 8'hFF;
      tick();
      tests_run++;
      if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_wr_in_rst got=%b want=0", wr_valid); end
      i_csn_50m = 1'b1; i_wr_50m = 1'b0;
      rst_50m = 1'b0;
      gpio_in = 8'h00;
      tick();
      tests_run++;
      if (wr_valid !== 1'b0 || rd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_after wv=%b rv=%b want 0/0", wr_valid, rd_valid);
      end
      bus_read(2'd0, d);
      tests_run++;
      if (d !== 8'h00) begin tests_failed++; $display("FAIL abort_mask got=%h want=00", d); end
   endtask

   initial begin
      test_reset();
      test_bus_timing();
      test_fixed_prio();
      test_cancel();
      test_level();
      test_arbitration_order();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/gpio_int_arb.md
GPIO_INT_ARB -- requirements
Module: gpio_int_arb

Interface
REQ-001 Parameter N_SRC, default 8: number of GPIO interrupt sources; fixed at 8 in this revision, INT_CODE width 3.
REQ-002 clk_50m  input  1  single clock; all logic on its rising edge.
REQ-003 rst_50m  input  1  reset; synchronous, active-high.
REQ-004 gpio_in  input  8  raw GPIO interrupt sources; asynchronous.
REQ-005 i_csn_50m  input  1  bus chip select, active-low.
REQ-006 i_wr_50m  input  1  bus write strobe, qualified by i_csn_50m low.
REQ-007 i_rd_50m  input  1  bus read strobe, qualified by i_csn_50m low.
REQ-008 i_addr_50m  input  2  register address.
REQ-009 i_datin_50m  input  8  write data.
REQ-010 o_datout_50m  output  8  read data; valid only while rd_valid is 1.
REQ-011 wr_valid  output  1  one-cycle write-accepted pulse.
REQ-012 rd_valid  output  1  one-cycle read-data-valid pulse.
REQ-013 INTR  output  1  interrupt request to CPU, active-high.
REQ-014 INT_CODE  output  3  index of the source being requested.
REQ-015 INTA_N  input  1  CPU interrupt acknowledge, active-low.

Function
REQ-016 gpio_in SHALL pass through a 2-flop synchronizer; event detection SHALL use the synchronized value and its 1-cycle delayed copy.
REQ-017 Registers: 0=MASK (RW, 1=enabled), 1=PEND (read; write-1-to-clear), 2=MODE (RW, 1=rising edge, 0=level-high), 3=LAST (RO, {5'b0, last acknowledged code}).
REQ-018 PEND[i] SHALL set on a rising edge of synced gpio_in[i] (MODE[i]=1) or while synced gpio_in[i]=1 (MODE[i]=0), regardless of MASK.
REQ-019 Set SHALL win over a simultaneous write-1-clear or acknowledge clear of the same PEND bit.
REQ-020 Write access: cycle where i_csn_50m falls with i_wr_50m=1; register updates at the next edge; wr_valid=1 exactly 1 cycle after the falling edge.
REQ-021 Read access: cycle where i_csn_50m falls with i_rd_50m=1; rd_valid=1 and o_datout_50m=register value exactly 2 cycles after the falling edge; o_datout_50m=0 otherwise.
REQ-022 Only one access per i_csn_50m falling edge; a held-low i_csn_50m SHALL NOT retrigger.
REQ-023 Active set A = PEND & MASK; fixed priority, bit 0 highest.
REQ-024 FSM states IDLE, REQ, ACK; reset state IDLE.
REQ-025 IDLE->REQ when A != 0: INTR=1 next cycle, INT_CODE=winner index latched and held stable through REQ.
REQ-026 REQ->ACK on first cycle INTA_N=0: INTR SHALL be 0 on the following cycle; PEND[INT_CODE] cleared and LAST loaded in that same edge.
REQ-027 INTA_N already 0 at entry to REQ SHALL count as acknowledge on the first REQ cycle, so INTR pulses for exactly one cycle.
REQ-028 ACK->IDLE when INTA_N=1; no new INTR while in ACK.
REQ-029 If the latched source is masked or cleared by software while in REQ, FSM SHALL return to IDLE with INTR=0 on the next cycle, without updating LAST.
REQ-030 INT_CODE SHALL hold its last value in IDLE and ACK.

Reset
REQ-031 rst_50m=1 at a rising edge: MASK=0x00, PEND=0x00, MODE=0xFF, LAST=0, synchronizer flops=0, FSM=IDLE, INTR=0, INT_CODE=0, o_datout_50m=0, wr_valid=0, rd_valid=0.
REQ-032 Reset mid-access or mid-handshake SHALL abort it; no wr_valid/rd_valid pulse follows.

Configuration
REQ-033 Macro GPIO_INT_ARB_RR_EN defined: round-robin priority, search starting at (last acknowledged code + 1) mod 8, pointer reset to 0 so first search starts at bit 0.
REQ-034 Macro undefined: fixed priority per REQ-023; no pointer logic present.

Verification
REQ-035 Reset held 3 cycles -> INTR=0, INT_CODE=0, o_datout_50m=0; read MASK=0x00, MODE=0xFF.
REQ-036 Write MASK=0x0A; rising edge on gpio_in[3] and gpio_in[1] same cycle -> INTR=1 with INT_CODE=1; INTA_N low 1 cycle -> INTR=0 next cycle; second INTR with INT_CODE=3 (RR build: same order from reset).
REQ-037 CSN falls with wr=1 -> wr_valid exactly 1 cycle later; CSN falls with rd=1 on addr 1 -> rd_valid exactly 2 cycles later with PEND value.
REQ-038 MODE=0x00, MASK=0x01, gpio_in[0] held high -> PEND[0] stays 1 through acknowledge; INTR re-raises after INTA_N returns high.
REQ-039 MASK=0x04, edge on gpio_in[2]; in REQ write MASK=0x00 -> INTR=0 next cycle, FSM IDLE, LAST unchanged.
REQ-040 RR build: MASK=0xFF, gpio_in[0] and gpio_in[5] edges repeated after each acknowledge -> INT_CODE alternates 0,5,0,5.
